// File: rtl/jt12_ring_sched.sv
// jt12_ring_sched
// Slot scheduler and write arbiter for a per-slot recirculating shift-register
// ring. It counts time-division slots and recirculates the ring word. One
// pending write is injected as its target slot passes the tap. After reset the
// ring is flushed to rstval before any write is accepted.
//
// Optional feature: define JT12_RING_RDBACK_EN to add single-slot readback.
//
// Parameters:
//   width   data bits per slot
//   stages  slots in the ring (> 2), equals the ring depth
//   rstval  bit replicated into every ring bit during reset/flush
//
// Ports (sw = $clog2(stages)):
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   clk_en    in   slot advance enable
//   ring_out  in   [width] word leaving the ring for the current slot
//   ring_in   out  [width] word entering the ring (combinational)
//   slot      out  [sw] slot index of the word on ring_out
//   zero      out  high while slot == 0
//   ready     out  ring flushed, writes may be accepted
//   wr_req    in   write request (level)
//   wr_slot   in   [sw] target slot
//   wr_data   in   [width] word to inject
//   rd_req    in   readback request            (JT12_RING_RDBACK_EN only)
//   rd_slot   in   [sw] readback slot          (JT12_RING_RDBACK_EN only)
//   rd_busy   out  readback pending            (JT12_RING_RDBACK_EN only)
//   rd_data   out  [width] captured word       (JT12_RING_RDBACK_EN only)
//   rd_valid  out  one-clk pulse on capture    (JT12_RING_RDBACK_EN only)
//   wr_busy   out  a write is pending
//   wr_ack    out  one-clk pulse: pending write completed
//   wr_err    out  one-clk pulse with wr_ack when the write was discarded
module jt12_ring_sched #(
    parameter int   width  = 5,
    parameter int   stages = 24,
    parameter logic rstval = 1'b0,
    localparam int  sw     = $clog2(stages)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [width-1:0] ring_out,
    output logic [width-1:0] ring_in,
    output logic [sw-1:0]    slot,
    output logic             zero,
    output logic             ready,
    input  logic             wr_req,
    input  logic [sw-1:0]    wr_slot,
    input  logic [width-1:0] wr_data,
`ifdef JT12_RING_RDBACK_EN
    input  logic             rd_req,
    input  logic [sw-1:0]    rd_slot,
    output logic             rd_busy,
    output logic [width-1:0] rd_data,
    output logic             rd_valid,
`endif
    output logic             wr_busy,
    output logic             wr_ack,
    output logic             wr_err
);

    localparam logic [sw-1:0] SLOT_LAST = sw'(stages - 1);

    logic [sw-1:0]    slot_q,  slot_d;
    logic             zero_q,  zero_d;
    logic             ready_q, ready_d;
    logic [sw-1:0]    fcnt_q,  fcnt_d;
    logic             wbusy_q, wbusy_d;
    logic [sw-1:0]    wslot_q, wslot_d;
    logic [width-1:0] wdata_q, wdata_d;
    logic             ack_q,   ack_d;
    logic             err_q,   err_d;
    logic             w_oor;
    logic             w_hit;

    always_comb begin
        slot_d  = slot_q;
        ready_d = ready_q;
        fcnt_d  = fcnt_q;
        wbusy_d = wbusy_q;
        wslot_d = wslot_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        if (clk_en) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end
        zero_d = (slot_d == '0);

        // Flush: the stages-th clk_en edge after reset sets ready, so exactly
        // one full revolution is overwritten with rstval.
        if (!ready_q && clk_en) begin
            if (fcnt_q == SLOT_LAST) begin
                ready_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        w_oor = (32'(wslot_q) >= stages);
        w_hit = wbusy_q && clk_en && !w_oor && (slot_q == wslot_q);

        // Acceptance is gated by the registered busy flag, so the completing
        // edge can never accept a new request.
        if (wbusy_q) begin
            if (w_oor) begin
                wbusy_d = 1'b0;
                ack_d   = 1'b1;
                err_d   = 1'b1;
            end else if (w_hit) begin
                wbusy_d = 1'b0;
                ack_d   = 1'b1;
            end
        end else if (wr_req && ready_q) begin
            wbusy_d = 1'b1;
            wslot_d = wr_slot;
            wdata_d = wr_data;
        end

        if (rst || !ready_q) begin
            ring_in = {width{rstval}};
        end else if (w_hit) begin
            ring_in = wdata_q;
        end else begin
            ring_in = ring_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q  <= '0;
            zero_q  <= 1'b1;
            ready_q <= 1'b0;
            fcnt_q  <= '0;
            wbusy_q <= 1'b0;
            wslot_q <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            zero_q  <= zero_d;
            ready_q <= ready_d;
            fcnt_q  <= fcnt_d;
            wbusy_q <= wbusy_d;
            wslot_q <= wslot_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign slot    = slot_q;
    assign zero    = zero_q;
    assign ready   = ready_q;
    assign wr_busy = wbusy_q;
    assign wr_ack  = ack_q;
    assign wr_err  = err_q;

`ifdef JT12_RING_RDBACK_EN
    logic             rbusy_q,  rbusy_d;
    logic [sw-1:0]    rslot_q,  rslot_d;
    logic [width-1:0] rdata_q,  rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             r_oor;

    // Capture samples ring_out, not ring_in, so a same-slot write on the same
    // edge yields the old word.
    always_comb begin
        rbusy_d  = rbusy_q;
        rslot_d  = rslot_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        r_oor    = (32'(rslot_q) >= stages);
        if (rbusy_q) begin
            if (r_oor) begin
                rbusy_d = 1'b0;
            end else if (clk_en && (slot_q == rslot_q)) begin
                rbusy_d  = 1'b0;
                rdata_d  = ring_out;
                rvalid_d = 1'b1;
            end
        end else if (rd_req && ready_q) begin
            rbusy_d = 1'b1;
            rslot_d = rd_slot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rbusy_q  <= 1'b0;
            rslot_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rbusy_q  <= rbusy_d;
            rslot_q  <= rslot_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rd_busy  = rbusy_q;
    assign rd_data  = rdata_q;
    assign rd_valid = rvalid_q;
`endif

endmodule

// File: tb/tb_jt12_ring_sched.sv
// Testbench for jt12_ring_sched: models the external shift-register ring,
// a slot counter and the expected ring contents; writes go through a
// scoreboard queue popped on each wr_ack.
module tb_jt12_ring_sched;

    localparam int W  = 5;
    localparam int ST = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_en;
    logic [W-1:0] ring_out;
    logic [W-1:0] ring_in;
    logic [4:0]   slot;
    logic         zero;
    logic         ready;
    logic         wr_req;
    logic [4:0]   wr_slot;
    logic [W-1:0] wr_data;
    logic         wr_busy;
    logic         wr_ack;
    logic         wr_err;
`ifdef JT12_RING_RDBACK_EN
    logic         rd_req;
    logic [4:0]   rd_slot;
    logic         rd_busy;
    logic [W-1:0] rd_data;
    logic         rd_valid;
`endif

    always #5 clk = ~clk;

    jt12_ring_sched #(.width(W), .stages(ST), .rstval(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .ring_out (ring_out),
        .ring_in  (ring_in),
        .slot     (slot),
        .zero     (zero),
        .ready    (ready),
        .wr_req   (wr_req),
        .wr_slot  (wr_slot),
        .wr_data  (wr_data),
`ifdef JT12_RING_RDBACK_EN
        .rd_req   (rd_req),
        .rd_slot  (rd_slot),
        .rd_busy  (rd_busy),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
`endif
        .wr_busy  (wr_busy),
        .wr_ack   (wr_ack),
        .wr_err   (wr_err)
    );

    // External ring; preload fills it with junk before the first flush.
    logic [W-1:0] ring_q [ST];
    logic         preload;
    assign ring_out = ring_q[ST-1];

    always @(posedge clk) begin
        if (clk_en) begin
            for (int i = ST - 1; i > 0; i--) ring_q[i] <= ring_q[i-1];
            ring_q[0] <= preload ? W'($urandom) : ring_in;
        end
    end

    logic [4:0] exp_slot;
    always @(posedge clk) begin
        if (rst)         exp_slot <= '0;
        else if (clk_en) exp_slot <= (exp_slot == 5'(ST - 1)) ? 5'd0 : exp_slot + 5'd1;
    end

    typedef struct {
        logic [4:0]   slot;
        logic [W-1:0] data;
        logic         err;
    } sb_t;

    typedef struct {
        logic [4:0]   start;
        logic [4:0]   wslot;
        logic [W-1:0] wdata;
        int           lat;
        logic         err;
    } vec_t;

    sb_t          sb[$];
    sb_t          e_pop;
    logic [W-1:0] exp_mem [32];
    bit           started = 0;
    bit           mon_en  = 0;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("slot", 32'(slot), 32'(exp_slot));
            chk("zero", 32'(zero), 32'(exp_slot == 5'd0));
        end
        if (mon_en) chk("ring_word", 32'(ring_out), 32'(exp_mem[exp_slot]));
        if (wr_ack) begin
            chk("busy_low_at_ack", 32'(wr_busy), 0);
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL ack_unexpected: got wr_ack=1 expected no ack (t=%0t)", $time);
            end else begin
                e_pop = sb.pop_front();
                chk("wr_err", 32'(wr_err), 32'(e_pop.err));
                if (!e_pop.err) exp_mem[e_pop.slot] = e_pop.data;
            end
        end else if (wr_err) begin
            n_checks++;
            n_errors++;
            $display("FAIL err_without_ack: got wr_err=1 expected 0 (t=%0t)", $time);
        end
    end

    task automatic wait_slot(input logic [4:0] s);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (exp_slot == s) found = 1;
        end
        if (!found) chk("wait_slot_timeout", 0, 1);
    endtask

    // Counts clk edges after the accept edge until wr_ack is seen.
    task automatic wait_ack(output int n);
        bit got = 0;
        n = 0;
        while (!got && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (wr_ack) got = 1;
        end
        if (!got) chk("ack_timeout", 0, 1);
    endtask

    task automatic write_one(input logic [4:0] s, input logic [W-1:0] d, input logic err);
        wr_req  = 1'b1;
        wr_slot = s;
        wr_data = d;
        sb.push_back('{s, d, err});
        @(posedge clk);
        #1 wr_req = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", 32'(wr_busy), 1);
    endtask

    // Assumes entry at a negedge; leaves at the negedge after ready rises.
    task automatic reset_flush(input int cycles);
        mon_en = 0;
        rst    = 1'b1;
        clk_en = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            started = 1;
            chk("rst_ring_in", 32'(ring_in), 0);
            chk("rst_ready", 32'(ready), 0);
            chk("rst_busy", 32'(wr_busy), 0);
            chk("rst_ack", 32'(wr_ack), 0);
            chk("rst_err", 32'(wr_err), 0);
        end
        rst     = 1'b0;
        // Requests during the flush must be dropped.
        wr_req  = 1'b1;
        wr_slot = 5'd4;
        wr_data = 5'h1F;
        for (int e = 0; e < ST; e++) begin
            chk("flush_ring_in", 32'(ring_in), 0);
            chk("flush_ready", 32'(ready), 0);
            chk("flush_busy", 32'(wr_busy), 0);
            @(negedge clk);
        end
        wr_req = 1'b0;
        chk("ready_after_flush", 32'(ready), 1);
        chk("slot_after_flush", 32'(slot), 0);
        chk("busy_after_flush", 32'(wr_busy), 0);
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        mon_en = 1;
    endtask

    vec_t vecs [8];
    int   lat;
    int   b2b_lat [4];
    logic [4:0]   b2b_slot [4];
    logic [W-1:0] b2b_data [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{5'd5,  5'd10, 5'h1B, 5,  1'b0};
        vecs[1] = '{5'd7,  5'd7,  5'h15, 24, 1'b0};
        vecs[2] = '{5'd0,  5'd1,  5'h1F, 1,  1'b0};
        vecs[3] = '{5'd23, 5'd0,  5'h01, 1,  1'b0};
        vecs[4] = '{5'd12, 5'd30, 5'h0E, 1,  1'b1};
        vecs[5] = '{5'd20, 5'd3,  5'h0A, 7,  1'b0};
        vecs[6] = '{5'd3,  5'd23, 5'h11, 20, 1'b0};
        vecs[7] = '{5'd10, 5'd24, 5'h07, 1,  1'b1};
        b2b_slot = '{5'd4, 5'd9, 5'd15, 5'd20};
        b2b_data = '{5'h03, 5'h1C, 5'h09, 5'h16};
        b2b_lat  = '{4, 4, 5, 4};

        rst     = 1'b1;
        clk_en  = 1'b1;
        preload = 1'b1;
        wr_req  = 1'b0;
        wr_slot = '0;
        wr_data = '0;
`ifdef JT12_RING_RDBACK_EN
        rd_req  = 1'b0;
        rd_slot = '0;
`endif
        repeat (ST) @(negedge clk);
        preload = 1'b0;
        reset_flush(3);

        // Table-driven single writes.
        for (int i = 0; i < 8; i++) begin
            wait_slot(vecs[i].start);
            write_one(vecs[i].wslot, vecs[i].wdata, vecs[i].err);
            wait_ack(lat);
            chk($sformatf("latency_v%0d", i), 32'(lat), 32'(vecs[i].lat));
        end

`ifdef JT12_RING_RDBACK_EN
        // Slot 3 holds 5'h0A from the table.
        wait_slot(5'd10);
        rd_req  = 1'b1;
        rd_slot = 5'd3;
        @(posedge clk);
        #1 rd_req = 1'b0;
        begin
            bit got = 0;
            int n = 0;
            while (!got && n < 60) begin
                @(posedge clk);
                n++;
                @(negedge clk);
                if (rd_valid) got = 1;
            end
            chk("rd_valid_seen", 32'(got), 1);
            chk("rd_latency", 32'(n), 17);
            chk("rd_data", 32'(rd_data), 32'h0A);
        end
`endif

        // Stall: accept with clk_en low, hold 10 clk, then resume.
        wait_slot(5'd2);
        clk_en = 1'b0;
        write_one(5'd6, 5'h13, 1'b0);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            chk("stall_slot", 32'(slot), 2);
            chk("stall_busy", 32'(wr_busy), 1);
            chk("stall_no_ack", 32'(wr_ack), 0);
        end
        clk_en = 1'b1;
        wait_ack(lat);
        chk("latency_stall", 32'(lat), 5);

        // Back-to-back with wr_req held and data changing after each ack.
        wait_slot(5'd0);
        wr_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_slot = b2b_slot[k];
            wr_data = b2b_data[k];
            sb.push_back('{b2b_slot[k], b2b_data[k], 1'b0});
            @(posedge clk);
            if (k == 3) #1 wr_req = 1'b0;
            @(negedge clk);
            chk("b2b_busy", 32'(wr_busy), 1);
            wait_ack(lat);
            chk($sformatf("b2b_latency_%0d", k), 32'(lat), 32'(b2b_lat[k]));
        end

        // Reset while a write is pending: no ack, ring re-flushed.
        wait_slot(5'd1);
        write_one(5'd0, 5'h1E, 1'b0);
        repeat (3) @(negedge clk);
        chk("pending_before_rst", 32'(wr_busy), 1);
        void'(sb.pop_back());
        reset_flush(2);
        repeat (2 * ST) @(negedge clk);

        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
